// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator.
// Divides clk down to a pixel tick, runs the horizontal/vertical pixel counters and produces
// registered hsync/vsync plus the video_on, line_end and frame_end decodes. Default timing is
// 640x480 @ 60 Hz from a 50 MHz clock (DIV = 2).
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   p_tick     out  one-clk pixel enable, once every DIV clocks (constant 1 when DIV = 1)
//   pix_x      out  horizontal count, 0..H_TOTAL-1
//   pix_y      out  vertical count, 0..V_TOTAL-1
//   video_on   out  high while inside the visible area
//   hsync      out  registered horizontal sync, active level SYNC_POL
//   vsync      out  registered vertical sync, active level SYNC_POL
//   line_end   out  pulse on the last pixel tick of each line
//   frame_end  out  pulse on the last pixel tick of each frame
module vga_sync_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned DIV       = 2,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // 11-bit constants so a total of exactly 1024 still compares correctly.
  localparam logic [10:0] HLast     = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast     = 11'(V_TOTAL - 1);
  localparam logic [10:0] HDisp     = 11'(H_DISPLAY);
  localparam logic [10:0] VDisp     = 11'(V_DISPLAY);
  localparam logic [10:0] HSyncLo   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HSyncHi   = 11'(H_DISPLAY + H_FRONT + H_SYNC);  // exclusive
  localparam logic [10:0] VSyncLo   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VSyncHi   = 11'(V_DISPLAY + V_FRONT + V_SYNC);  // exclusive

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : gen_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (DIV < 1) begin : gen_bad_div
    $error("vga_sync_gen: DIV must be at least 1");
  end

  // Pixel tick divider
  if (DIV == 1) begin : gen_no_div
    assign p_tick = 1'b1;
  end else begin : gen_div
    localparam int unsigned DivW    = $clog2(DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

    logic [DivW-1:0] div_cnt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        div_cnt_q <= '0;
      end else if (div_cnt_q == DivLast) begin
        div_cnt_q <= '0;
      end else begin
        div_cnt_q <= div_cnt_q + DivW'(1);
      end
    end

    assign p_tick = (div_cnt_q == DivLast);
  end

  // Pixel counters and syncs
  logic [9:0] pix_x_q, pix_x_d;
  logic [9:0] pix_y_q, pix_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       x_last, y_last;

  assign x_last = ({1'b0, pix_x_q} == HLast);
  assign y_last = ({1'b0, pix_y_q} == VLast);

  always_comb begin
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    if (p_tick) begin
      if (x_last) begin
        pix_x_d = '0;
        pix_y_d = y_last ? 10'd0 : pix_y_q + 10'd1;
      end else begin
        pix_x_d = pix_x_q + 10'd1;
      end
    end
    // Decode from the next counts so the registered syncs line up with pix_x/pix_y.
    hsync_d = ({1'b0, pix_x_d} >= HSyncLo && {1'b0, pix_x_d} < HSyncHi) ? SYNC_POL : ~SYNC_POL;
    vsync_d = ({1'b0, pix_y_d} >= VSyncLo && {1'b0, pix_y_d} < VSyncHi) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x_q <= '0;
      pix_y_q <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = ({1'b0, pix_x_q} < HDisp) && ({1'b0, pix_y_q} < VDisp);
  assign line_end  = p_tick && x_last;
  assign frame_end = line_end && y_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen. Three instances: default timing (DIV=2, active-low syncs), a shrunken
// timing (15x11, DIV=3) so whole frames fit in a short run, and default timing with DIV=1 and
// active-high syncs. Every cycle each instance is compared against a closed-form model that
// derives the expected outputs from the number of clocks since its last reset.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic rst_a;
  logic pt_a, vo_a, hs_a, vs_a, le_a, fe_a;
  logic [9:0] x_a, y_a;
  // Instance S: small timing, DIV = 3
  logic rst_s;
  logic pt_s, vo_s, hs_s, vs_s, le_s, fe_s;
  logic [9:0] x_s, y_s;
  // Instance O: DIV = 1, active-high syncs
  logic rst_o;
  logic pt_o, vo_o, hs_o, vs_o, le_o, fe_o;
  logic [9:0] x_o, y_o;

  vga_sync_gen u_def (
    .clk(clk), .reset(rst_a), .p_tick(pt_a), .pix_x(x_a), .pix_y(y_a), .video_on(vo_a),
    .hsync(hs_a), .vsync(vs_a), .line_end(le_a), .frame_end(fe_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .DIV(3), .SYNC_POL(1'b0)
  ) u_small (
    .clk(clk), .reset(rst_s), .p_tick(pt_s), .pix_x(x_s), .pix_y(y_s), .video_on(vo_s),
    .hsync(hs_s), .vsync(vs_s), .line_end(le_s), .frame_end(fe_s)
  );

  vga_sync_gen #(
    .DIV(1), .SYNC_POL(1'b1)
  ) u_one (
    .clk(clk), .reset(rst_o), .p_tick(pt_o), .pix_x(x_o), .pix_y(y_o), .video_on(vo_o),
    .hsync(hs_o), .vsync(vs_o), .line_end(le_o), .frame_end(fe_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the output state after c clean clocks following reset.
  // Packing: {p_tick, pix_x, pix_y, video_on, hsync, vsync, line_end, frame_end}
  function automatic logic [25:0] model(input int unsigned c,
                                        input int unsigned hd, input int unsigned hf,
                                        input int unsigned hs, input int unsigned hb,
                                        input int unsigned vd, input int unsigned vf,
                                        input int unsigned vs, input int unsigned vb,
                                        input int unsigned dv, input bit pol);
    int unsigned ht = hd + hf + hs + hb;
    int unsigned vt = vd + vf + vs + vb;
    int unsigned ticks = c / dv;
    int unsigned pos = ticks % (ht * vt);
    int unsigned x = pos % ht;
    int unsigned y = pos / ht;
    bit pt = ((c % dv) == dv - 1);
    bit vo = (x < hd) && (y < vd);
    bit hsv = (x >= hd + hf && x < hd + hf + hs) ? pol : !pol;
    bit vsv = (y >= vd + vf && y < vd + vf + vs) ? pol : !pol;
    bit le = pt && (x == ht - 1);
    bit fe = le && (y == vt - 1);
    return {pt, 10'(x), 10'(y), vo, hsv, vsv, le, fe};
  endfunction

  // Clocks since each instance's last reset edge
  int unsigned c_a = 0, c_s = 0, c_o = 0;
  bit val_a, val_s, val_o;

  always @(posedge clk) begin
    if (rst_a) begin c_a <= 0; val_a <= 1'b1; end else c_a <= c_a + 1;
    if (rst_s) begin c_s <= 0; val_s <= 1'b1; end else c_s <= c_s + 1;
    if (rst_o) begin c_o <= 0; val_o <= 1'b1; end else c_o <= c_o + 1;
  end

  always @(negedge clk) begin
    if (val_a)
      chk("model_def", 32'({pt_a, x_a, y_a, vo_a, hs_a, vs_a, le_a, fe_a}),
          32'(model(c_a, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0)));
    if (val_s)
      chk("model_small", 32'({pt_s, x_s, y_s, vo_s, hs_s, vs_s, le_s, fe_s}),
          32'(model(c_s, 8, 2, 3, 2, 5, 1, 2, 3, 3, 1'b0)));
    if (val_o)
      chk("model_div1", 32'({pt_o, x_o, y_o, vo_o, hs_o, vs_o, le_o, fe_o}),
          32'(model(c_o, 640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b1)));
  end

  // Directed vectors for the default instance: clocks since release -> expected outputs
  typedef struct {
    int unsigned c;
    logic        pt;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        vo;
    logic        hs;
    logic        vs;
    logic        le;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int le_cnt, hs_clks, hs_ticks, first_lo, last_lo;
    int fe_cnt, vs_ticks, vo_ticks, first_fe, max_x, max_y, pt_cnt, first_le;
    logic [5:0] ph;

    tbl[0]  = '{c: 0,    pt: 0, x: 0,   y: 0, vo: 1, hs: 1, vs: 1, le: 0};
    tbl[1]  = '{c: 1,    pt: 1, x: 0,   y: 0, vo: 1, hs: 1, vs: 1, le: 0};
    tbl[2]  = '{c: 2,    pt: 0, x: 1,   y: 0, vo: 1, hs: 1, vs: 1, le: 0};
    tbl[3]  = '{c: 3,    pt: 1, x: 1,   y: 0, vo: 1, hs: 1, vs: 1, le: 0};
    tbl[4]  = '{c: 1279, pt: 1, x: 639, y: 0, vo: 1, hs: 1, vs: 1, le: 0};
    tbl[5]  = '{c: 1280, pt: 0, x: 640, y: 0, vo: 0, hs: 1, vs: 1, le: 0};
    tbl[6]  = '{c: 1311, pt: 1, x: 655, y: 0, vo: 0, hs: 1, vs: 1, le: 0};
    tbl[7]  = '{c: 1312, pt: 0, x: 656, y: 0, vo: 0, hs: 0, vs: 1, le: 0};
    tbl[8]  = '{c: 1503, pt: 1, x: 751, y: 0, vo: 0, hs: 0, vs: 1, le: 0};
    tbl[9]  = '{c: 1504, pt: 0, x: 752, y: 0, vo: 0, hs: 1, vs: 1, le: 0};
    tbl[10] = '{c: 1598, pt: 0, x: 799, y: 0, vo: 0, hs: 1, vs: 1, le: 0};
    tbl[11] = '{c: 1599, pt: 1, x: 799, y: 0, vo: 0, hs: 1, vs: 1, le: 1};
    tbl[12] = '{c: 1600, pt: 0, x: 0,   y: 1, vo: 1, hs: 1, vs: 1, le: 0};

    rst_a = 1'b1; rst_s = 1'b1; rst_o = 1'b1;
    repeat (3) @(negedge clk);
    // Held in reset: outputs stay at reset values, DIV=1 tick stays high
    chk("reset_hold_def", 32'({pt_a, x_a, y_a, vo_a, hs_a, vs_a, le_a, fe_a}),
        32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
    chk("reset_hold_div1", 32'({pt_o, x_o, y_o, hs_o, vs_o}),
        32'({1'b1, 10'd0, 10'd0, 1'b0, 1'b0}));
    rst_a = 1'b0; rst_s = 1'b0; rst_o = 1'b0;

    // Table-driven walk through the first line of the default instance
    for (int i = 0; i < 13; i++) begin
      for (int g = 0; g < 2000 && c_a < tbl[i].c; g++) @(negedge clk);
      chk("table_def", 32'({pt_a, x_a, y_a, vo_a, hs_a, vs_a, le_a}),
          32'({tbl[i].pt, tbl[i].x, tbl[i].y, tbl[i].vo, tbl[i].hs, tbl[i].vs, tbl[i].le}));
    end

    // One full line after a fresh reset: hsync pulse width/position, single line_end
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    le_cnt = 0; hs_clks = 0; hs_ticks = 0; first_lo = -1; last_lo = -1;
    for (int k = 0; k < 1600; k++) begin
      if (!hs_a) begin
        hs_clks++;
        if (first_lo < 0) first_lo = int'(x_a);
        last_lo = int'(x_a);
        if (pt_a) hs_ticks++;
      end
      if (le_a) le_cnt++;
      @(negedge clk);
    end
    chk("line_hsync_clks", 32'(hs_clks), 32'd192);
    chk("line_hsync_ticks", 32'(hs_ticks), 32'd96);
    chk("line_hsync_first_x", 32'(first_lo), 32'd656);
    chk("line_hsync_last_x", 32'(last_lo), 32'd751);
    chk("line_end_count", 32'(le_cnt), 32'd1);
    chk("line_wrap_xy", 32'({x_a, y_a}), 32'({10'd0, 10'd1}));

    // Small instance: reset with both syncs active, then three full frames
    rst_s = 1'b1; @(negedge clk); rst_s = 1'b0;
    repeat (348) @(negedge clk);
    chk("mid_state", 32'({x_s, y_s, hs_s, vs_s}), 32'({10'd11, 10'd7, 1'b0, 1'b0}));
    rst_s = 1'b1; @(negedge clk); rst_s = 1'b0;
    chk("mid_reset", 32'({pt_s, x_s, y_s, hs_s, vs_s, le_s, fe_s}),
        32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}));
    ph = 6'b100100;
    fe_cnt = 0; le_cnt = 0; vs_ticks = 0; vo_ticks = 0; first_fe = -1; max_x = 0; max_y = 0;
    for (int k = 0; k < 1485; k++) begin
      if (k < 6) chk("tick_phase", 32'(pt_s), 32'(ph[k]));
      if (pt_s && !vs_s) vs_ticks++;
      if (pt_s && vo_s) vo_ticks++;
      if (le_s) le_cnt++;
      if (fe_s) begin
        fe_cnt++;
        if (first_fe < 0) first_fe = k;
      end
      if (int'(x_s) > max_x) max_x = int'(x_s);
      if (int'(y_s) > max_y) max_y = int'(y_s);
      @(negedge clk);
    end
    chk("frame_end_count", 32'(fe_cnt), 32'd3);
    chk("frame_first_end", 32'(first_fe), 32'd494);
    chk("frame_line_ends", 32'(le_cnt), 32'd33);
    chk("frame_vsync_ticks", 32'(vs_ticks), 32'd90);
    chk("frame_video_ticks", 32'(vo_ticks), 32'd120);
    chk("frame_max_x", 32'(max_x), 32'd14);
    chk("frame_max_y", 32'(max_y), 32'd10);
    chk("frame_wrap_xy", 32'({x_s, y_s}), 32'({10'd0, 10'd0}));

    // DIV = 1, active-high syncs: one line
    rst_o = 1'b1; @(negedge clk);
    chk("div1_tick_in_reset", 32'({pt_o, x_o}), 32'({1'b1, 10'd0}));
    rst_o = 1'b0;
    pt_cnt = 0; hs_clks = 0; le_cnt = 0; first_le = -1; first_lo = -1; last_lo = -1;
    for (int k = 0; k < 800; k++) begin
      if (pt_o) pt_cnt++;
      if (hs_o) begin
        hs_clks++;
        if (first_lo < 0) first_lo = int'(x_o);
        last_lo = int'(x_o);
      end
      if (le_o) begin
        le_cnt++;
        if (first_le < 0) first_le = k;
      end
      @(negedge clk);
    end
    chk("div1_tick_count", 32'(pt_cnt), 32'd800);
    chk("div1_hsync_clks", 32'(hs_clks), 32'd96);
    chk("div1_hsync_first_x", 32'(first_lo), 32'd656);
    chk("div1_hsync_last_x", 32'(last_lo), 32'd751);
    chk("div1_line_end_at", 32'(first_le), 32'd799);
    chk("div1_wrap_xy", 32'({x_o, y_o}), 32'({10'd0, 10'd1}));

    // Random reset pulses at arbitrary phases; the per-cycle model check covers recovery
    for (int i = 0; i < 6000; i++) begin
      rst_a = ($urandom_range(299) == 0);
      rst_s = ($urandom_range(99) == 0);
      rst_o = ($urandom_range(199) == 0);
      @(negedge clk);
    end
    rst_a = 1'b0; rst_s = 1'b0; rst_o = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
